mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter for an instruction-fetch port and a data port.
// Data requests win over fetch by default. Optional fairness (define ARB_FAIRNESS_EN)
// forces a fetch grant after FAIR_LIMIT consecutive data grants while fetch waits.
// At most one read is in flight; stores complete in their issue cycle.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned FAIR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_d,
  output logic        busy
);

  if (MEM_LAT < 1 || MEM_LAT > 7 || FAIR_LIMIT < 1) begin : gen_bad_param
    $error("mem_port_arbiter: MEM_LAT must be 1..7 and FAIR_LIMIT at least 1");
  end

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        owner_q;      // 1 = data port owns the in-flight read
  logic        byte_q;
  logic [1:0]  off_q;
  logic        if_rvalid_q, d_rvalid_q;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic        grant_d, grant_if, fair_hit, capture;
  logic [7:0]  sel_byte;
  logic [31:0] load_val;
  logic        unused_bits;

  // Fetch words are always aligned; the low address bits carry no meaning.
  assign unused_bits = ^if_addr[1:0];

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned FairW = $clog2(FAIR_LIMIT + 1);
  logic [FairW-1:0] fair_q;

  assign fair_hit = ({{(32 - FairW){1'b0}}, fair_q} >= FAIR_LIMIT);

  // Count data grants that overtook a waiting fetch; any fetch grant clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      fair_q <= '0;
    end else if (grant_if) begin
      fair_q <= '0;
    end else if (grant_d && if_req) begin
      fair_q <= fair_q + 1'b1;
    end
  end
`else
  assign fair_hit = 1'b0;
`endif

  // Grants only in IDLE; reset suppresses every grant in the same cycle.
  assign grant_d  = ~reset & (state_q == StIdle) & d_req & ~(fair_hit & if_req);
  assign grant_if = ~reset & (state_q == StIdle) & if_req & ~grant_d;
  assign capture  = (state_q == StRdWait) && (cnt_q == 3'd0);

  // Next-state: a read grant waits MEM_LAT cycles, capture on the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if ((grant_d && !d_we) || grant_if) begin
          state_d = StRdWait;
          cnt_d   = 3'(MEM_LAT - 1);
        end
      end
      StRdWait: begin
        if (cnt_q == 3'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Little-endian byte select with sign extension for byte loads.
  always_comb begin
    sel_byte = mem_rdata[7:0];
    unique case (off_q)
      2'd0: sel_byte = mem_rdata[7:0];
      2'd1: sel_byte = mem_rdata[15:8];
      2'd2: sel_byte = mem_rdata[23:16];
      2'd3: sel_byte = mem_rdata[31:24];
      default: sel_byte = mem_rdata[7:0];
    endcase
    load_val = byte_q ? {{24{sel_byte[7]}}, sel_byte} : mem_rdata;
  end

  // State, access context captured at grant, and registered read results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      owner_q     <= 1'b0;
      byte_q      <= 1'b0;
      off_q       <= 2'd0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if_rvalid_q <= capture & ~owner_q;
      d_rvalid_q  <= capture & owner_q;
      if (grant_d || grant_if) begin
        owner_q <= grant_d;
        byte_q  <= d_byte;
        off_q   <= d_addr[1:0];
      end
      if (capture && !owner_q) begin
        if_rdata_q <= mem_rdata;
      end
      if (capture && owner_q) begin
        d_rdata_q <= load_val;
      end
    end
  end

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = grant_d | grant_if;
  assign mem_we    = grant_d & d_we;
  assign mem_addr  = grant_d ? {d_addr[31:2], 2'b00} : {if_addr[31:2], 2'b00};
  assign mem_wdata = d_wdata;
  assign stall_if  = if_req & ~grant_if;
  assign stall_d   = d_req & ~grant_d;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (MEM_LAT = 2, FAIR_LIMIT = 4).
module tb_mem_port_arbiter;
  localparam int MemLat = 2;

  logic        clk = 1'b0;
  logic        reset, if_req, d_req, d_we, d_byte;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall_if, stall_d, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.MEM_LAT(MemLat), .FAIR_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_d(stall_d), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0040_0000: mem_word = 32'h8FA4_0004;
      32'h0040_0004: mem_word = 32'h1111_2222;
      32'h1001_0000: mem_word = 32'h80FF_1234;
      default:       mem_word = a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  // Memory model: read data only during cycle issue+MemLat, garbage otherwise.
  int          cyc = 0;
  int          issue_cyc = -100;
  logic [31:0] issue_addr = '0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (cyc == issue_cyc + MemLat) mem_rdata <= mem_word(issue_addr);
    else                           mem_rdata <= 32'hDEAD_BEEF;
    if (mem_en && !mem_we) begin
      issue_cyc  <= cyc;
      issue_addr <= mem_addr;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
    end
  endtask

  task automatic push(input bit is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every rvalid pulse must match the oldest expected response.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (if_rvalid || d_rvalid) begin
        total++;
        if (if_rvalid && d_rvalid) begin
          bad++;
          $display("FAIL rvalid_both: got if=1 d=1 expected at most one");
        end else if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rvalid: got if=%0b d=%0b data 0x%08h/0x%08h expected none",
                   if_rvalid, d_rvalid, if_rdata, d_rdata);
        end else begin
          exp_t e = exp_q.pop_front();
          if (e.is_d != d_rvalid || (d_rvalid ? d_rdata : if_rdata) !== e.data) begin
            bad++;
            $display("FAIL rdata: got port_d=%0b data 0x%08h expected port_d=%0b data 0x%08h",
                     d_rvalid, d_rvalid ? d_rdata : if_rdata, e.is_d, e.data);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [31:0] a, input logic [31:0] want, input bit bsel);
    d_req = 1; d_we = 0; d_byte = bsel; d_addr = a;
    push(1'b1, want);
    @(negedge clk);
    chk("load_gnt", {31'd0, d_gnt}, 32'd1);
    chk("load_maddr", mem_addr, {a[31:2], 2'b00});
    tick();
    // Changed inputs after grant must not affect the result; request held off.
    d_byte = ~bsel; d_addr = 32'h1001_0002;
    @(negedge clk);
    chk("rdwait_stall_d", {30'd0, stall_d, d_gnt}, 32'd2);
    tick();
    d_req = 0;
    repeat (3) tick();
  endtask

  initial begin
    int n_if, n_d, first_if;
    reset = 1; if_req = 1; d_req = 1; d_we = 0; d_byte = 0;
    if_addr = 32'h0040_0000; d_addr = 32'h1001_0000; d_wdata = '0; mem_rdata = '0;
    fork
      monitor();
    join_none
    tick();
    @(negedge clk);
    chk("rst_grants", {28'd0, if_gnt, d_gnt, mem_en, mem_we}, 32'd0);
    chk("rst_state", {28'd0, busy, if_rvalid, d_rvalid, 1'b0}, 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    if_req = 0; d_req = 0;
    tick();

    // Fetch read, MEM_LAT = 2.
    reset = 0; if_req = 1; if_addr = 32'h0040_0000;
    push(1'b0, 32'h8FA4_0004);
    @(negedge clk);
    chk("fetch_gnt", {29'd0, if_gnt, mem_en, mem_we}, 32'd6);
    chk("fetch_maddr", mem_addr, 32'h0040_0000);
    tick(); if_req = 0;
    @(negedge clk); chk("busy_t1", {31'd0, busy}, 32'd1);
    tick();
    @(negedge clk); chk("busy_t2", {31'd0, busy}, 32'd1);
    tick();
    @(negedge clk); chk("rvalid_t3", {30'd0, busy, if_rvalid}, 32'd1);
    tick();

    // Simultaneous requests: data store first, fetch next cycle.
    d_req = 1; d_we = 1; d_addr = 32'h1001_0008; d_wdata = 32'h1234_5678;
    if_req = 1; if_addr = 32'h0040_0004;
    @(negedge clk);
    chk("both_gnt", {28'd0, d_gnt, if_gnt, mem_we, stall_if}, 32'hB);
    chk("store_maddr", mem_addr, 32'h1001_0008);
    chk("store_wdata", mem_wdata, 32'h1234_5678);
    tick(); d_req = 0; d_we = 0;
    push(1'b0, 32'h1111_2222);
    @(negedge clk);
    chk("fetch_after_store", {30'd0, if_gnt, busy}, 32'd2);
    tick(); if_req = 0;
    repeat (3) tick();

    // Byte and word loads.
    load_byte(32'h1001_0003, 32'hFFFF_FF80, 1'b1);
    load_byte(32'h1001_0001, 32'h0000_0012, 1'b1);
    load_byte(32'h1001_0000, 32'h80FF_1234, 1'b0);

    // Reset during RD_WAIT aborts the read.
    if_req = 1; if_addr = 32'h0040_0000;
    @(negedge clk); chk("abort_gnt", {31'd0, if_gnt}, 32'd1);
    tick(); if_req = 0; reset = 1;
    tick(); reset = 0; if_req = 1; if_addr = 32'h0040_0004;
    push(1'b0, 32'h1111_2222);
    @(negedge clk);
    chk("post_rst_gnt", {30'd0, busy, if_gnt}, 32'd1);
    tick(); if_req = 0;
    repeat (4) tick();

    // Data stores held for 10 cycles with fetch waiting.
    d_req = 1; d_we = 1; d_addr = 32'h1001_0008; if_req = 1; if_addr = 32'h0040_0000;
    n_if = 0; n_d = 0; first_if = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (if_gnt) begin
        n_if++;
        if (first_if == 0) first_if = i;
        push(1'b0, 32'h8FA4_0004);
      end
      if (d_gnt) n_d++;
      tick();
    end
    d_req = 0; d_we = 0; if_req = 0;
`ifdef ARB_FAIRNESS_EN
    chk("fair_if_cnt", n_if, 1);
    chk("fair_first_if", first_if, 5);
    chk("fair_d_cnt", n_d, 7);
`else
    chk("strict_if_cnt", n_if, 0);
    chk("strict_d_cnt", n_d, 10);
`endif
    repeat (5) tick();

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
